// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word and MIPS instruction field widths.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef logic [5:0]  opcode_t;
    typedef logic [5:0]  funct_t;
    typedef logic [4:0]  regbits_t;
endpackage

// File: rtl/data_path_muxs_pkg.sv
// Datapath control types shared across pipeline stages; holds the fetch FSM encoding.
package data_path_muxs_pkg;
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        PEND   = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;
endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline latch: flush beats stall beats load, and an enabled cycle with nothing
// to deliver advances a bubble. Instruction fields are pure slices of the latched word.
module if_id_reg
    import cpu_types_pkg::*;
(
    input  logic     CLK,
    input  logic     nRST,
    input  logic     enable,
    input  logic     flush,
    input  logic     loadValid,
    input  word_t    fetchWord,
    input  word_t    fetchPc,
    input  word_t    fetchNpc,
    output word_t    instruction,
    output word_t    pcOut,
    output word_t    npcOut,
    output logic     validOut,
    output opcode_t  opcode,
    output funct_t   func,
    output regbits_t rs,
    output regbits_t rt,
    output regbits_t rd,
    output logic [15:0] imm16
);
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            instruction <= '0;
            pcOut       <= '0;
            npcOut      <= '0;
            validOut    <= 1'b0;
        end else if (flush || (enable && !loadValid)) begin
            instruction <= '0;
            pcOut       <= '0;
            npcOut      <= '0;
            validOut    <= 1'b0;
        end else if (enable) begin
            instruction <= fetchWord;
            pcOut       <= fetchPc;
            npcOut      <= fetchNpc;
            validOut    <= 1'b1;
        end
    end

    assign opcode = instruction[31:26];
    assign func   = instruction[5:0];
    assign rs     = instruction[25:21];
    assign rt     = instruction[20:16];
    assign rd     = instruction[15:11];
    assign imm16  = instruction[15:0];
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, request FSM (RUN/PEND/HALTED) and the IF/ID latch.
// Optional FETCH_PERF_CNT_EN adds saturating fetch_count / stall_count outputs.
module fetch_stage
    import cpu_types_pkg::*, data_path_muxs_pkg::*;
#(
    parameter word_t PC_INIT    = 32'h0000_0000,
    parameter word_t WORD_BYTES = 32'd4
) (
    input  logic     CLK,
    input  logic     nRST,
    input  logic     ihit,
    input  word_t    imemload,
    output logic     imemREN,
    output word_t    imemaddr,
    input  logic     enable_IF_ID,
    input  logic     flush_IF_ID,
    input  logic     redirect_valid,
    input  word_t    redirect_pc,
    input  logic     halt_dec,
    output word_t    instruction_IF_ID,
    output word_t    imemaddr_IF_ID,
    output word_t    npc_IF_ID,
    output logic     valid_IF_ID,
    output opcode_t  opcode_IF_ID,
    output funct_t   func_IF_ID,
    output regbits_t Rs_IF_ID,
    output regbits_t Rt_IF_ID,
    output regbits_t Rd_IF_ID,
`ifdef FETCH_PERF_CNT_EN
    output word_t    fetch_count,
    output word_t    stall_count,
`endif
    output logic [15:0] imm16_IF_ID
);
    fetch_state_t state;
    word_t        pc;
    word_t        pendPc;
    word_t        pcPlus;
    logic         loadValid;

    assign pcPlus   = pc + WORD_BYTES;
    assign imemREN  = (state != HALTED);
    assign imemaddr = pc;
    // Only a RUN-state hit that is not being squashed or halted delivers a real instruction.
    assign loadValid = (state == RUN) && ihit && !redirect_valid && !halt_dec;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= RUN;
            pc     <= PC_INIT;
            pendPc <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (redirect_valid) begin
                        if (ihit) begin
                            pc <= redirect_pc;
                        end else begin
                            // Request in flight: keep imemaddr stable, remember the target.
                            pendPc <= redirect_pc;
                            state  <= PEND;
                        end
                    end else if (halt_dec) begin
                        state <= HALTED;
                    end else if (ihit && enable_IF_ID) begin
                        pc <= pcPlus;
                    end
                end
                PEND: begin
                    if (ihit) begin
                        pc    <= redirect_valid ? redirect_pc : pendPc;
                        state <= RUN;
                    end else if (redirect_valid) begin
                        pendPc <= redirect_pc;
                    end
                end
                HALTED: begin
                    if (redirect_valid) begin
                        pc    <= redirect_pc;
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    if_id_reg u_if_id_reg (
        .CLK         (CLK),
        .nRST        (nRST),
        .enable      (enable_IF_ID),
        .flush       (flush_IF_ID),
        .loadValid   (loadValid),
        .fetchWord   (imemload),
        .fetchPc     (pc),
        .fetchNpc    (pcPlus),
        .instruction (instruction_IF_ID),
        .pcOut       (imemaddr_IF_ID),
        .npcOut      (npc_IF_ID),
        .validOut    (valid_IF_ID),
        .opcode      (opcode_IF_ID),
        .func        (func_IF_ID),
        .rs          (Rs_IF_ID),
        .rt          (Rt_IF_ID),
        .rd          (Rd_IF_ID),
        .imm16       (imm16_IF_ID)
    );

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fetch_count <= '0;
            stall_count <= '0;
        end else if (state != HALTED) begin
            if (loadValid && enable_IF_ID && !flush_IF_ID && fetch_count != '1)
                fetch_count <= fetch_count + 32'd1;
            if ((!ihit || !enable_IF_ID) && stall_count != '1)
                stall_count <= stall_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboarded bench for fetch_stage: directed plan then random traffic vs a behavioural model.
module tb_fetch_stage;
    import cpu_types_pkg::*;

    localparam word_t PC_INIT = 32'h0000_0000;

    logic     CLK = 1'b0;
    logic     nRST = 1'b0;
    logic     ihit = 1'b0;
    word_t    imemload = '0;
    logic     imemREN;
    word_t    imemaddr;
    logic     enable_IF_ID = 1'b0;
    logic     flush_IF_ID = 1'b0;
    logic     redirect_valid = 1'b0;
    word_t    redirect_pc = '0;
    logic     halt_dec = 1'b0;
    word_t    instruction_IF_ID, imemaddr_IF_ID, npc_IF_ID;
    logic     valid_IF_ID;
    opcode_t  opcode_IF_ID;
    funct_t   func_IF_ID;
    regbits_t Rs_IF_ID, Rt_IF_ID, Rd_IF_ID;
    logic [15:0] imm16_IF_ID;
`ifdef FETCH_PERF_CNT_EN
    word_t    fetch_count, stall_count;
`endif

    fetch_stage #(.PC_INIT(PC_INIT), .WORD_BYTES(32'd4)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload),
        .imemREN(imemREN), .imemaddr(imemaddr),
        .enable_IF_ID(enable_IF_ID), .flush_IF_ID(flush_IF_ID),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt_dec(halt_dec),
        .instruction_IF_ID(instruction_IF_ID), .imemaddr_IF_ID(imemaddr_IF_ID),
        .npc_IF_ID(npc_IF_ID), .valid_IF_ID(valid_IF_ID),
        .opcode_IF_ID(opcode_IF_ID), .func_IF_ID(func_IF_ID),
        .Rs_IF_ID(Rs_IF_ID), .Rt_IF_ID(Rt_IF_ID), .Rd_IF_ID(Rd_IF_ID),
`ifdef FETCH_PERF_CNT_EN
        .fetch_count(fetch_count), .stall_count(stall_count),
`endif
        .imm16_IF_ID(imm16_IF_ID)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic  ren;
        word_t addr;
        word_t instr;
        word_t ifAddr;
        word_t npc;
        logic  valid;
        word_t fcnt;
        word_t scnt;
    } exp_t;

    exp_t sbQ[$];
    int total = 0;
    int bad = 0;

    // Behavioural model: fetch pointer, outstanding redirect target, halt flag, latched slot.
    word_t mPc, mPend, mInstr, mIfAddr, mNpc, mFcnt, mScnt;
    bit    mWait, mHalt, mValid;

    task automatic chk(string name, word_t act, word_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t snap();
        exp_t e;
        e.ren = !mHalt; e.addr = mPc; e.instr = mInstr; e.ifAddr = mIfAddr;
        e.npc = mNpc; e.valid = mValid; e.fcnt = mFcnt; e.scnt = mScnt;
        return e;
    endfunction

    task automatic modelReset();
        mPc = PC_INIT; mPend = '0; mWait = 0; mHalt = 0;
        mInstr = '0; mIfAddr = '0; mNpc = '0; mValid = 0; mFcnt = '0; mScnt = '0;
    endtask

    task automatic modelAdvance(bit h, word_t ld, bit en, bit fl, bit rv, word_t rp, bit hd);
        bit    deliver;
        word_t fetchedAt;
        fetchedAt = mPc;
        deliver = 0;
        if (!mHalt && (!h || !en) && mScnt != 32'hFFFF_FFFF) mScnt = mScnt + 1;
        if (mHalt) begin
            if (rv) begin mPc = rp; mHalt = 0; end
        end else if (mWait) begin
            if (rv) mPend = rp;
            if (h) begin mPc = mPend; mWait = 0; end
        end else begin
            deliver = h && !rv && !hd;
            if (rv) begin
                if (h) mPc = rp;
                else begin mPend = rp; mWait = 1; end
            end else if (hd) mHalt = 1;
            else if (h && en) mPc = mPc + 4;
        end
        if (fl || (en && !deliver)) begin
            mInstr = '0; mIfAddr = '0; mNpc = '0; mValid = 0;
        end else if (en) begin
            mInstr = ld; mIfAddr = fetchedAt; mNpc = fetchedAt + 4; mValid = 1;
            if (mFcnt != 32'hFFFF_FFFF) mFcnt = mFcnt + 1;
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(bit r, bit h, word_t ld, bit en, bit fl, bit rv, word_t rp, bit hd);
        nRST = r; ihit = h; imemload = ld; enable_IF_ID = en; flush_IF_ID = fl;
        redirect_valid = rv; redirect_pc = rp; halt_dec = hd;
        if (!r) begin
            modelReset();
            #1;
            chk("rst_imemaddr", imemaddr, PC_INIT);
            chk("rst_imemREN", {31'b0, imemREN}, 32'd1);
            chk("rst_valid", {31'b0, valid_IF_ID}, 32'd0);
        end else begin
            modelAdvance(h, ld, en, fl, rv, rp, hd);
        end
        sbQ.push_back(snap());
        @(negedge CLK);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (sbQ.size() > 0) begin
                e = sbQ.pop_front();
                chk("imemREN", {31'b0, imemREN}, {31'b0, e.ren});
                chk("imemaddr", imemaddr, e.addr);
                chk("instruction", instruction_IF_ID, e.instr);
                chk("imemaddr_IF_ID", imemaddr_IF_ID, e.ifAddr);
                chk("npc_IF_ID", npc_IF_ID, e.npc);
                chk("valid_IF_ID", {31'b0, valid_IF_ID}, {31'b0, e.valid});
                chk("opcode", {26'b0, opcode_IF_ID}, {26'b0, e.instr[31:26]});
                chk("func", {26'b0, func_IF_ID}, {26'b0, e.instr[5:0]});
                chk("Rs", {27'b0, Rs_IF_ID}, {27'b0, e.instr[25:21]});
                chk("Rt", {27'b0, Rt_IF_ID}, {27'b0, e.instr[20:16]});
                chk("Rd", {27'b0, Rd_IF_ID}, {27'b0, e.instr[15:11]});
                chk("imm16", {16'b0, imm16_IF_ID}, {16'b0, e.instr[15:0]});
`ifdef FETCH_PERF_CNT_EN
                chk("fetch_count", fetch_count, e.fcnt);
                chk("stall_count", stall_count, e.scnt);
`endif
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timed out");
    end

    initial begin : stimulus
        word_t rp;
        modelReset();
        @(negedge CLK);
        step(0, 0, '0, 0, 0, 0, '0, 0);
        step(0, 0, '0, 0, 0, 0, '0, 0);

        // Three sequential hits
        step(1, 1, 32'h2001_0005, 1, 0, 0, '0, 0);
        chk("seq0_imemaddr", imemaddr, 32'h4);
        chk("seq0_ifaddr", imemaddr_IF_ID, 32'h0);
        chk("seq0_npc", npc_IF_ID, 32'h4);
        chk("seq0_rt", {27'b0, Rt_IF_ID}, 32'd1);
        step(1, 1, 32'h2002_0007, 1, 0, 0, '0, 0);
        chk("seq1_ifaddr", imemaddr_IF_ID, 32'h4);
        chk("seq1_npc", npc_IF_ID, 32'h8);
        chk("seq1_rt", {27'b0, Rt_IF_ID}, 32'd2);
        step(1, 1, 32'h0000_000C, 1, 0, 0, '0, 0);
        chk("seq2_imemaddr", imemaddr, 32'hC);
        chk("seq2_npc", npc_IF_ID, 32'hC);
        step(1, 1, 32'h0000_0000, 1, 0, 0, '0, 0);

        // Stall at 0x10
        step(1, 1, 32'hAAAA_0001, 0, 0, 0, '0, 0);
        step(1, 1, 32'hAAAA_0002, 0, 0, 0, '0, 0);
        chk("stall_imemaddr", imemaddr, 32'h10);
        chk("stall_ifaddr", imemaddr_IF_ID, 32'hC);
        step(1, 1, 32'h3C01_1234, 1, 0, 0, '0, 0);
        chk("unstall_ifaddr", imemaddr_IF_ID, 32'h10);
        chk("unstall_instr", instruction_IF_ID, 32'h3C01_1234);
        for (int i = 0; i < 3; i++) step(1, 1, $urandom, 1, 0, 0, '0, 0);

        // Redirect while request outstanding
        step(1, 0, '0, 1, 0, 1, 32'h100, 0);
        chk("pend_imemaddr0", imemaddr, 32'h20);
        step(1, 0, '0, 1, 0, 0, '0, 0);
        chk("pend_imemaddr1", imemaddr, 32'h20);
        step(1, 1, 32'hDEAD_BEEF, 1, 0, 0, '0, 0);
        chk("pend_done_imemaddr", imemaddr, 32'h100);
        chk("pend_done_valid", {31'b0, valid_IF_ID}, 32'd0);

        // Flush beats stall
        step(1, 1, 32'h1234_5678, 0, 1, 0, '0, 0);
        chk("flush_instr", instruction_IF_ID, 32'h0);
        chk("flush_imemaddr", imemaddr, 32'h100);

        // Halt and resume
        step(1, 1, $urandom, 1, 0, 1, 32'h40, 0);
        step(1, 1, $urandom, 1, 0, 0, '0, 1);
        chk("halt_ren", {31'b0, imemREN}, 32'd0);
        for (int i = 0; i < 3; i++) step(1, i[0], $urandom, 1, 0, 0, '0, 0);
        chk("halt_hold_ren", {31'b0, imemREN}, 32'd0);
        step(1, 0, '0, 1, 0, 1, 32'h80, 0);
        chk("resume_imemaddr", imemaddr, 32'h80);
        chk("resume_ren", {31'b0, imemREN}, 32'd1);

        // Reset in the middle of a pending redirect
        step(1, 0, '0, 1, 0, 1, 32'h200, 0);
        step(0, 0, '0, 1, 0, 0, '0, 0);
        step(1, 1, 32'h0800_0000, 1, 0, 0, '0, 0);
        chk("postrst_ifaddr", imemaddr_IF_ID, PC_INIT);
        chk("postrst_imemaddr", imemaddr, PC_INIT + 4);

        // Address wrap
        step(1, 1, $urandom, 1, 0, 1, 32'hFFFF_FFF8, 0);
        step(1, 1, $urandom, 1, 0, 0, '0, 0);
        step(1, 1, $urandom, 1, 0, 0, '0, 0);
        chk("wrap_ifaddr", imemaddr_IF_ID, 32'hFFFF_FFFC);
        chk("wrap_npc", npc_IF_ID, 32'h0);
        chk("wrap_imemaddr", imemaddr, 32'h0);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            rp = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'h0000_FFFC);
            step(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) < 7), $urandom,
                 ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 11) == 0), rp, ($urandom_range(0, 29) == 0));
        end

        step(1, 0, '0, 0, 0, 0, '0, 0);
        @(posedge CLK);
        #2;
        chk("sb_drain", sbQ.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage: owns the PC, issues instruction requests to the I-side memory/cache, and latches the fetched word into the IF/ID pipeline register.
- Directly upstream of decode; its IF/ID outputs feed register-file read and the ID/EX register.
- Handles stalls from hazard control, squashes from the EX-stage redirect, and halt.
- An FSM holds the request address stable until ihit, because redirects can arrive mid-request.

Parameters:
- PC_INIT, 32'h0000_0000, PC value after reset.
- WORD_BYTES, 4, PC increment per sequential fetch.

Ports:
- CLK  input  1  clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- ihit  input  1  instruction memory returned imemload for the current imemaddr this cycle.
- imemload  input  32  instruction word from memory.
- imemREN  output  1  instruction read request.
- imemaddr  output  32  fetch address; equals current PC, or the held address in PEND.
- enable_IF_ID  input  1  1 = IF/ID may advance; 0 = stall, hold IF/ID and PC.
- flush_IF_ID  input  1  load a bubble into IF/ID next edge.
- redirect_valid  input  1  taken branch/jump resolved downstream.
- redirect_pc  input  32  target PC.
- halt_dec  input  1  halt opcode present in ID.
- instruction_IF_ID  output  32  latched instruction.
- imemaddr_IF_ID  output  32  PC of latched instruction.
- npc_IF_ID  output  32  imemaddr_IF_ID + WORD_BYTES.
- valid_IF_ID  output  1  IF/ID holds a real instruction.
- opcode_IF_ID  output  opcode_t  instruction[31:26].
- func_IF_ID  output  funct_t  instruction[5:0].
- Rs_IF_ID, Rt_IF_ID, Rd_IF_ID  output  regbits_t each  [25:21], [20:16], [15:11].
- imm16_IF_ID  output  16  instruction[15:0].

Behaviour:
- Reset (nRST low, asynchronous):
  - PC = PC_INIT, state = RUN.
  - All IF/ID registers = 0; valid_IF_ID = 0; pend_pc = 0.
  - imemREN = 1, imemaddr = PC_INIT, since outputs are combinational from state.
- Field outputs are pure slices of instruction_IF_ID. The all-zero instruction is a nop (sll $0).
- Output decode:
  - imemREN = (state != HALTED).
  - imemaddr = PC in RUN and PEND; PC in HALTED, with imemREN = 0.
- State RUN:
  - ihit & enable & !redirect & !flush: IF/ID <= {imemload, PC, PC+4}, valid 1; PC <= PC+4 (32-bit wrap, 32'hFFFF_FFFC -> 0).
  - ihit & redirect: returned word is wrong-path. IF/ID <= bubble if enable; PC <= redirect_pc; stay RUN.
  - !ihit & redirect: pend_pc <= redirect_pc; go to PEND; PC and imemaddr unchanged.
  - !enable (stall), no redirect: PC and IF/ID hold even on ihit; the word is refetched later.
  - !enable & redirect: PC/pend redirect still taken as above; IF/ID holds unless flushed.
  - halt_dec & !redirect: go to HALTED at the edge; PC holds; no new IF/ID load.
- State PEND:
  - imemaddr held at the old PC.
  - A new redirect overwrites pend_pc.
  - On ihit: data discarded, PC <= pend_pc (or redirect_pc if asserted that cycle), IF/ID <= bubble if enable, go to RUN.
- State HALTED:
  - imemREN = 0.
  - redirect_valid squashes the halt: PC <= redirect_pc, go to RUN.
  - Otherwise stays until reset.
- Priority for IF/ID: flush > stall (!enable) > load. Flush writes all-zero with valid 0, regardless of enable.
- Priority for PC: redirect > halt > stall > sequential.
- Latency: fetched word visible on IF/ID outputs the cycle after ihit.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined, adds two outputs:
  - fetch_count, 32: increments on each valid IF/ID load.
  - stall_count, 32: increments each cycle with imemREN & (!ihit | !enable).
- Both counters reset to 0, saturate at 32'hFFFF_FFFF, and freeze in HALTED.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Decomposition:
- fetch_state_t enum {RUN, PEND, HALTED} goes in data_path_muxs_pkg.
- opcode_t, funct_t, regbits_t and word_t come from cpu_types_pkg.
- One natural sub-module: if_id_reg. It is the pipeline latch with enable/flush priority and field slicing.
- The FSM and PC live in fetch_stage.

Test Plan:
- Reset, then ihit=1 and enable=1 for 3 cycles with imemload = 0x2001_0005, 0x2002_0007, 0x0000_000C.
  -> imemaddr 0, 4, 8 then 0xC.
  -> IF/ID gets imemaddr_IF_ID 0/4/8, npc 4/8/C, Rt_IF_ID 1 then 2.
- Stall: enable=0 for 2 cycles with ihit=1 at PC=0x10.
  -> PC stays 0x10; IF/ID unchanged.
  -> Re-enable: IF/ID loads the word from 0x10.
- Redirect with ihit=0 at PC=0x20, redirect_pc=0x100.
  -> PEND; imemaddr stays 0x20 until ihit.
  -> Next cycle imemaddr=0x100; IF/ID valid_IF_ID=0.
- Simultaneous flush=1, enable=0, ihit=1.
  -> IF/ID all-zero, valid 0; PC unchanged.
- halt_dec=1 at PC=0x40.
  -> imemREN=0 next cycle and stays low.
  -> Later redirect_pc=0x80 -> RUN, imemaddr=0x80.
- Assert nRST low mid-PEND (pend_pc=0x200).
  -> Immediately imemaddr=PC_INIT, valid 0.
  -> After release, fetch starts from PC_INIT; 0x200 is never fetched.
